// File: rtl/bpm_pkg.sv
// rtl/bpm_pkg.sv - shared defaults, FSM states and interval limits for the BPM estimator
package bpm_pkg;

  localparam int unsigned DEF_MAX_BPM       = 200;
  localparam int unsigned DEF_MIN_BPM       = 30;
  localparam int unsigned DEF_TICKS_PER_MIN = 60000;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } bpm_state_e;

  // Shortest acceptable beat interval; never below 1 so the divisor cannot be zero.
  function automatic int unsigned min_int(input int unsigned ticks, input int unsigned max_bpm);
    int unsigned v;
    v = ticks / max_bpm;
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int unsigned max_int(input int unsigned ticks, input int unsigned min_bpm);
    return ticks / min_bpm;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - W-bit restoring divider, one quotient bit per cycle
// done flags the final step; the quotient register holds the result from the next cycle.
module seq_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CW = $clog2(W + 1);

  logic [W:0]    rem_q, rem_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [W:0]    shifted;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    shifted = {rem_q[W-1:0], quo_q[W-1]};
    done    = run_q && (cnt_q == CW'(W - 1));
    if (abort) begin
      run_d = 1'b0;
    end else if (start) begin
      rem_d = '0;
      quo_d = dividend;
      dvs_d = divisor;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (shifted >= {1'b0, dvs_q}) begin
        rem_d = shifted - {1'b0, dvs_q};
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = shifted;
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
      if (done) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/bpm_estimator.sv
// rtl/bpm_estimator.sv - heart-rate estimate from beat intervals on a 1 ms timebase
// Define BPM_AVG_EN to divide by the mean of the last four intervals instead of the latest.
module bpm_estimator
  import bpm_pkg::*;
#(
  parameter int unsigned MAX_BPM       = DEF_MAX_BPM,
  parameter int unsigned MIN_BPM       = DEF_MIN_BPM,
  parameter int unsigned TICKS_PER_MIN = DEF_TICKS_PER_MIN,
  parameter int unsigned INT_W         = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick_ms,
  input  logic                           beat_in,
  output logic [$clog2(MAX_BPM+1)-1:0]   BPM_estimate,
  output logic                           bpm_valid,
  output logic                           busy
);

  localparam int unsigned BW      = $clog2(MAX_BPM + 1);
  localparam int unsigned MIN_INT = min_int(TICKS_PER_MIN, MAX_BPM);
  localparam int unsigned MAX_INT = max_int(TICKS_PER_MIN, MIN_BPM);

  bpm_state_e        state_q, state_d;
  logic [INT_W-1:0]  cnt_q, cnt_d;
  logic [INT_W-1:0]  pend_div_q, pend_div_d;
  logic              pend_q, pend_d;
  logic              armed_q, armed_d;
  logic [BW-1:0]     bpm_q, bpm_d;
  logic              valid_q, valid_d;

  logic              beat_acc, meas, timeout;
  logic [INT_W-1:0]  new_div, div_divisor, div_quo;
  logic              div_start, div_done;

  // A beat at or past MAX_INT is still a beat: timeout only fires when none arrives.
  assign beat_acc = beat_in && (cnt_q >= INT_W'(MIN_INT));
  assign meas     = beat_acc && armed_q;
  assign timeout  = armed_q && !beat_acc && (cnt_q >= INT_W'(MAX_INT));

`ifdef BPM_AVG_EN
  logic [INT_W-1:0] hist_q [4];
  logic [INT_W-1:0] hist_d [4];
  logic [2:0]       hist_n_q, hist_n_d;
  logic [INT_W+1:0] hist_sum;

  always_comb begin
    hist_d   = hist_q;
    hist_n_d = hist_n_q;
    if (meas) begin
      hist_d[0] = cnt_q;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
      if (hist_n_q != 3'd4) hist_n_d = hist_n_q + 3'd1;
    end
    hist_sum = {2'b00, hist_d[0]} + {2'b00, hist_d[1]} + {2'b00, hist_d[2]} + {2'b00, hist_d[3]};
    new_div  = (hist_n_d == 3'd4) ? hist_sum[INT_W+1:2] : cnt_q;
    if (timeout) begin
      hist_n_d = '0;
      hist_d   = '{default: '0};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q   <= '{default: '0};
      hist_n_q <= '0;
    end else begin
      hist_q   <= hist_d;
      hist_n_q <= hist_n_d;
    end
  end
`else
  assign new_div = cnt_q;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (beat_acc) cnt_d = '0;
    else if (tick_ms && (cnt_q != {INT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_div_d  = pend_div_q;
    armed_d     = armed_q || beat_acc;
    bpm_d       = bpm_q;
    valid_d     = 1'b0;
    div_start   = 1'b0;
    div_divisor = new_div;
    case (state_q)
      IDLE: begin
        if (meas) begin
          div_start = 1'b1;
          pend_d    = 1'b0;
          state_d   = DIV;
        end else if (pend_q) begin
          div_start   = 1'b1;
          div_divisor = pend_div_q;
          pend_d      = 1'b0;
          state_d     = DIV;
        end
      end
      DIV: if (div_done) state_d = DONE;
      DONE: begin
        bpm_d   = (div_quo > INT_W'(MAX_BPM)) ? BW'(MAX_BPM) : div_quo[BW-1:0];
        valid_d = 1'b1;
        state_d = IDLE;
        if (pend_q) begin
          div_start   = 1'b1;
          div_divisor = pend_div_q;
          pend_d      = 1'b0;
          state_d     = DIV;
        end
      end
      default: state_d = IDLE;
    endcase
    // Beats landing while the divider is occupied queue one divisor; the newest replaces older ones.
    if (meas && (state_q != IDLE)) begin
      pend_d     = 1'b1;
      pend_div_d = new_div;
    end
    if (timeout) begin
      state_d   = IDLE;
      div_start = 1'b0;
      pend_d    = 1'b0;
      armed_d   = 1'b0;
      bpm_d     = '0;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      pend_div_q <= '0;
      armed_q    <= 1'b0;
      bpm_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pend_div_q <= pend_div_d;
      armed_q    <= armed_d;
      bpm_q      <= bpm_d;
      valid_q    <= valid_d;
    end
  end

  seq_divider #(.W(INT_W)) u_div (
    .clk      (clk),
    .rst_n    (reset),
    .start    (div_start),
    .abort    (timeout),
    .dividend (INT_W'(TICKS_PER_MIN)),
    .divisor  (div_divisor),
    .quotient (div_quo),
    .done     (div_done)
  );

  assign BPM_estimate = bpm_q;
  assign bpm_valid    = valid_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: doc/bpm_estimator.md
BPM_ESTIMATOR -- requirements
Module: bpm_estimator

Interface
REQ-001 Parameter MAX_BPM, default 200, upper clamp of the estimate; must match the downstream brightness filter.
REQ-002 Parameter MIN_BPM, default 30, lowest rate reported before timeout.
REQ-003 Parameter TICKS_PER_MIN, default 60000, number of tick_ms strobes per minute.
REQ-004 Parameter INT_W, default 16, width of the interval counter and divider.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 tick_ms  input  1  one-cycle timebase strobe, 1 ms.
REQ-008 beat_in  input  1  one-cycle heartbeat pulse from the detector.
REQ-009 BPM_estimate  output  $clog2(MAX_BPM+1)  registered rate; feeds the brightness filter directly.
REQ-010 bpm_valid  output  1  one-cycle pulse when BPM_estimate updates.
REQ-011 busy  output  1  high while a division is in progress.

Function
REQ-012 Interval counter increments on tick_ms and saturates at 2^INT_W-1.
REQ-013 MIN_INT = TICKS_PER_MIN/MAX_BPM (300), MAX_INT = TICKS_PER_MIN/MIN_BPM (2000), both elaboration-time constants.
REQ-014 beat_in with counter < MIN_INT: glitch, ignored; counter keeps running.
REQ-015 Accepted beat: clears the counter to 0 that cycle, even with a coincident tick_ms.
REQ-016 First accepted beat after reset or timeout only arms measurement; no division, no bpm_valid.
REQ-017 Later accepted beats: capture the counter value as the interval and request a division.
REQ-018 FSM states: IDLE, DIV, DONE.
REQ-019 IDLE->DIV on a request; DIV lasts INT_W cycles (one restoring quotient bit per cycle); DIV->DONE; DONE->IDLE, or DONE->DIV if a request is pending.
REQ-020 Quotient = TICKS_PER_MIN / divisor; clamped to MAX_BPM; written to BPM_estimate in DONE with bpm_valid=1.
REQ-021 Latency from accepted beat (IDLE) to bpm_valid: INT_W+2 cycles (18 by default).
REQ-022 Beat accepted during DIV/DONE: interval stored, one pending flag set; further beats overwrite the pending divisor (latest wins).
REQ-023 Counter reaching MAX_INT with no beat: timeout.
REQ-024 Timeout: aborts any division, clears the pending flag and history, sets BPM_estimate=0, pulses bpm_valid once, and returns to unarmed.
REQ-025 Timeout and beat in the same cycle: beat wins; counter < MAX_INT is checked first.
REQ-026 Divisor is never 0; MIN_INT >= 1 is guaranteed by the parameter check.
REQ-027 busy = (state != IDLE).

Reset
REQ-028 Reset asserted low, asynchronously, clears counter, history, pending flag and armed flag; state=IDLE, BPM_estimate=0, bpm_valid=0, busy=0.
REQ-029 Reset mid-DIV discards the division; no bpm_valid after release until a full new measurement completes.

Configuration
REQ-030 Macro BPM_AVG_EN defined: 4-entry interval history; divisor = sum>>2 once 4 intervals are held, latest interval before that.
REQ-031 Macro BPM_AVG_EN undefined: no history; divisor is always the latest interval.

Structure
REQ-032 Package bpm_pkg holds MAX_BPM, MIN_BPM, TICKS_PER_MIN defaults, the FSM state enum, and the MIN_INT/MAX_INT functions.
REQ-033 Sub-module seq_divider: INT_W-bit restoring divider with start/done handshake and synchronous abort.

Verification
REQ-034 Beats 500 ticks apart, BPM_AVG_EN off -> BPM_estimate=120, bpm_valid 18 cycles after the second beat.
REQ-035 BPM_AVG_EN on, intervals 400, 600, 500, 500 -> fourth result 120 (sum 2000>>2); first three 150, 100, 120.
REQ-036 Beat 100 ticks after the last accepted beat -> ignored, no bpm_valid; next beat at 500 total -> 120.
REQ-037 Interval 300 -> 200; interval 250 -> rejected; forced divisor 280 via pending path -> clamped to 200.
REQ-038 No beat for 2000 ticks -> BPM_estimate=0 with a single bpm_valid; next beat only arms measurement.
REQ-039 reset low during DIV cycle 8 -> outputs 0 immediately; no spurious bpm_valid after release.
